// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals of the ALU arbiter
interface alu_arbiter_if;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
  );
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 8-bit ALU between two requesters
// Optional grant counters enabled by ALU_ARB_GRANT_CNT_EN.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next;
  logic last, sel, grant, cap_id;
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end
  always_comb begin
    sel = (bus.req0_valid && bus.req1_valid) ? !last : bus.req1_valid;
    grant = !rst && state == IDLE && (bus.req0_valid || bus.req1_valid);
    next = state == IDLE ? (grant ? EXEC : IDLE) :
           state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
    bus.req0_ready = grant && !sel;
    bus.req1_ready = grant && sel;
    bus.rsp_valid = state == RESP;
  end
  // ALU operand registers double as the capture registers, so the ALU never sees requester glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      cap_id <= 1'b0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= '0;
      bus.rsp_data <= '0;
      bus.rsp_id <= 1'b0;
    end else begin
      state <= next;
      if (grant) begin
        bus.alu_a <= sel ? bus.req1_a : bus.req0_a;
        bus.alu_b <= sel ? bus.req1_b : bus.req0_b;
        bus.alu_op <= sel ? bus.req1_op : bus.req0_op;
        cap_id <= sel;
        last <= sel;
      end
      if (state == EXEC) begin
        bus.rsp_data <= bus.alu_result;
        bus.rsp_id <= cap_id;
      end
    end
  end
`ifdef ALU_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (grant) begin
      if (!sel && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (sel && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural shared ALU
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic id; logic [7:0] data;} exp_t;
  exp_t sbq[$];
  alu_arbiter_if bus();
`ifdef ALU_ARB_GRANT_CNT_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
  alu_arbiter #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1));
`else
  alu_arbiter #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[2:0];
      4'd6: return a >> b[2:0];
      4'd7: return a;
      default: return 8'h00;
    endcase
  endfunction
  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic drive(input bit id, input bit v, input logic [7:0] a, b, input logic [3:0] op);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic expect_rsp(input string name);
    int n = 0;
    exp_t e;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.rsp_valid) begin
      errors++;
      $display("FAIL %s: rsp_valid timeout got 0 required 1", name);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected response id=%0d data=%h", name, bus.rsp_id, bus.rsp_data);
    end else begin
      e = sbq.pop_front();
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin
        errors++;
        $display("FAIL %s: got id=%0d data=%h required id=%0d data=%h", name, bus.rsp_id, bus.rsp_data, e.id, e.data);
      end
    end
  endtask

  task automatic issue(input string name, input bit id, input logic [7:0] a, b, input logic [3:0] op, input logic [7:0] exp);
    @(negedge clk);
    drive(id, 1'b1, a, b, op);
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got 0 required 1", name);
    end
    sbq.push_back('{id, exp});
    @(negedge clk);
    drive(id, 1'b0, 8'h00, 8'h00, 4'h0);
    expect_rsp(name);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b0, 1'b1, 8'h11, 8'h22, 4'h1);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.alu_a, bus.alu_b, bus.alu_op} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.alu_a, bus.alu_b, bus.alu_op});
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b required 00", bus.req0_ready, bus.req1_ready);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    rst = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h05, 8'h03, 4'h0);
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got %b%b required 10", bus.req0_ready, bus.req1_ready);
    end
    sbq.push_back('{1'b0, 8'h08});
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hAA, 8'h55, 4'h2);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 8'h05 || bus.alu_b !== 8'h03 || bus.alu_op !== 4'h0) begin
      errors++;
      $display("FAIL single_exec: got v=%b a=%h b=%h op=%h required v=0 a=05 b=03 op=0", bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: rsp_valid got %b required 1", bus.rsp_valid);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    expect_rsp("single_rsp");
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: rsp_valid got %b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_tie;
    do_reset();
    drive(1'b0, 1'b1, 8'h02, 8'h02, 4'h0);
    drive(1'b1, 1'b1, 8'h09, 8'h04, 4'h1);
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: got %b%b required 10", bus.req0_ready, bus.req1_ready);
    end
    sbq.push_back('{1'b0, 8'h04});
    sbq.push_back('{1'b1, 8'h05});
    @(negedge clk);
    expect_rsp("tie_rsp0");
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie_second: got %b%b required 01", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
    expect_rsp("tie_rsp1");
    @(negedge clk);
  endtask

  task automatic test_back_to_back_backpressure;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 8'h10, 8'h20, 4'h3);
    sbq.push_back('{1'b0, 8'h30});
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b1, 1'b1, 8'h07, 8'h01, 4'h1);
    expect_rsp("bp_rsp0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h30 || bus.req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b data=%h rdy1=%b required v=1 data=30 rdy1=0", i, bus.rsp_valid, bus.rsp_data, bus.req1_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept1: got %b required 1", bus.req1_ready);
    end
    sbq.push_back('{1'b1, 8'h06});
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
    expect_rsp("bp_rsp1");
    @(negedge clk);
  endtask

  task automatic test_opcodes;
    issue("op_undef", 1'b0, 8'hFF, 8'h00, 4'hF, 8'h00);
    issue("op_sll", 1'b1, 8'h01, 8'h03, 4'h5, 8'h08);
    issue("op_xor", 1'b0, 8'hF0, 8'h3C, 4'h4, 8'hCC);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h40, 8'h01, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.alu_a, bus.alu_b, bus.alu_op} !== 30'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required 0", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.alu_a, bus.alu_b, bus.alu_op});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_rsp%0d: rsp_valid got 1 required 0", i);
      end
    end
    drive(1'b0, 1'b1, 8'h0A, 8'h0B, 4'h0);
    drive(1'b1, 1'b1, 8'h01, 8'h01, 4'h0);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_tie: got %b%b required 10", bus.req0_ready, bus.req1_ready);
    end
    sbq.push_back('{1'b0, 8'h15});
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
    expect_rsp("mid_rsp");
    @(negedge clk);
  endtask

`ifdef ALU_ARB_GRANT_CNT_EN
  task automatic test_counters;
    do_reset();
    for (int i = 0; i < 3; i++) issue("cnt_r0", 1'b0, 8'(i), 8'h01, 4'h0, 8'(i + 1));
    for (int i = 0; i < 2; i++) issue("cnt_r1", 1'b1, 8'(i), 8'h02, 4'h0, 8'(i + 2));
    checks++;
    if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL cnt_values: got %0d/%0d required 3/2", gnt_cnt0, gnt_cnt1);
    end
    do_reset();
    checks++;
    if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clear: got %0d/%0d required 0/0", gnt_cnt0, gnt_cnt1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back_backpressure();
    test_opcodes();
    test_reset_mid();
`ifdef ALU_ARB_GRANT_CNT_EN
    test_counters();
`endif
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses missing, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of grant counters (used only under REQ-030).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  in  1  operation request from requester 0 / 1.
REQ-005 SHALL have ports: req0_ready / req1_ready  out  1  request accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b / req1_a, req1_b  in  8  operands; req0_op / req1_op  in  4  ALU opcode.
REQ-007 SHALL have ports: alu_a, alu_b  out  8; alu_op  out  4  drive the shared 8-bit ALU.
REQ-008 SHALL have port: alu_result  in  8  combinational result from the shared ALU.
REQ-009 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  8; rsp_id  out  1  (requester index).

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-011 IDLE: if any reqN_valid, SHALL select one requester, assert its reqN_ready combinationally that cycle, capture its a/b/op and index into internal registers, go to EXEC at the next edge.
REQ-012 reqN_ready SHALL be high only in IDLE, only for the selected requester, never both at once.
REQ-013 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last wins; last-grant pointer updates on every grant.
REQ-014 EXEC: alu_a/alu_b/alu_op SHALL equal the captured operands; at the next edge rsp_data <= alu_result, rsp_id <= captured index, go to RESP.
REQ-015 alu_a/alu_b/alu_op SHALL hold the last captured values in all states (stable, no glitch from requester inputs).
REQ-016 RESP: rsp_valid SHALL be 1; rsp_data/rsp_id held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-017 Latency: accept in cycle N -> rsp_valid high from cycle N+2; minimum 3 cycles per operation; no new accept while in EXEC or RESP.
REQ-018 Opcode SHALL be passed through unmodified; undefined opcodes (8-15) return whatever alu_result gives (0 from the team ALU).
REQ-019 Requests deasserted before acceptance SHALL be dropped silently; no request queuing inside the block.
REQ-020 Requester inputs change during EXEC/RESP SHALL NOT affect rsp_data.

Reset
REQ-021 On rst high, immediately: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, alu_a/alu_b 0, alu_op 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-022 reqN_ready SHALL be 0 while rst is high.
REQ-023 Reset mid-operation (EXEC or RESP) SHALL abort the operation; no response is issued for it.

Configuration
REQ-030 Macro ALU_ARB_GRANT_CNT_EN defined: SHALL add outputs gnt_cnt0, gnt_cnt1 (CNT_W each), incremented on each grant to that requester, saturating at all-ones, cleared by rst.
REQ-031 Macro not defined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-040 Single op: req0 a=8'h05 b=8'h03 op=0, rsp_ready=1 -> req0_ready in accept cycle, rsp_valid two cycles later, rsp_data=8'h08, rsp_id=0.
REQ-041 Tie after reset: both valid, req0 ADD 2+2, req1 SUB 9-4, both held -> responses in order id0 data 8'h04, then id1 data 8'h05.
REQ-042 Backpressure: rsp_ready=0 for 5 cycles in RESP with req1 valid -> rsp_data stable, req1_ready stays 0; after rsp_ready=1, req1 accepted next cycle.
REQ-043 Undefined opcode 4'hF, a=8'hFF -> rsp_data=8'h00; SLL a=8'h01 b=8'h03 -> rsp_data=8'h08.
REQ-044 rst asserted during EXEC -> rsp_valid stays 0, all outputs 0, next request after release granted normally to req0 on tie.
REQ-045 With ALU_ARB_GRANT_CNT_EN: 3 req0 grants, 2 req1 grants -> gnt_cnt0=3, gnt_cnt1=2; rst clears both to 0.
